// File: rtl/pcpu_board_top.sv
// pcpu_board_top: SWORD board I/O top with a debug-word source, serial LED/7-segment drivers
// and a 640x480@60 VGA test pattern. A pipelined CPU later replaces the debug-word source.

module pcpu_serial #(
    parameter int W       = 16,
    parameter int SER_DIV = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] data_i,
    output logic         sclk_o,
    output logic         sdo_o,
    output logic         pen_o
);
    localparam int DW = SER_DIV > 1 ? $clog2(SER_DIV) : 1;
    localparam int NW = $clog2(W);
    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH} state_t;
    state_t        st_q, st_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [NW-1:0] n_q, n_d;
    logic          ph_q, ph_d, pen_q, pen_d, lc_q, lc_d;
    logic [DW-1:0] div_q;
    logic          tick;
    assign tick   = div_q == DW'(SER_DIV - 1);
    // Every output comes straight from a flop so the shift lines never glitch.
    assign sclk_o = ph_q;
    assign sdo_o  = sh_q[W-1];
    assign pen_o  = pen_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            st_q  <= S_LOAD;
            sh_q  <= '0;
            n_q   <= '0;
            ph_q  <= 1'b0;
            pen_q <= 1'b0;
            lc_q  <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            st_q  <= st_d;
            sh_q  <= sh_d;
            n_q   <= n_d;
            ph_q  <= ph_d;
            pen_q <= pen_d;
            lc_q  <= lc_d;
        end
    end
    always_comb begin
        st_d  = st_q;
        sh_d  = sh_q;
        n_d   = n_q;
        ph_d  = ph_q;
        pen_d = pen_q;
        lc_d  = lc_q;
        if (tick) begin
            case (st_q)
                S_LOAD: begin
                    sh_d  = data_i;
                    n_d   = '0;
                    ph_d  = 1'b0;
                    pen_d = 1'b0;
                    st_d  = S_SHIFT;
                end
                S_SHIFT: begin
                    ph_d = ~ph_q;
                    if (ph_q && n_q == NW'(W - 1)) begin
                        st_d  = S_LATCH;
                        pen_d = 1'b1;
                        lc_d  = 1'b0;
                    end else if (ph_q) begin
                        sh_d = {sh_q[W-2:0], 1'b0};
                        n_d  = n_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    lc_d  = 1'b1;
                    pen_d = ~lc_q;
                    st_d  = lc_q ? S_LOAD : S_LATCH;
                end
                default: st_d = S_LOAD;
            endcase
        end
    end
endmodule

module pcpu_board_top #(
    parameter int SER_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk_100mhz,
    input  logic        RSTN,
    input  logic        clk200P,
    input  logic        clk200N,
    output logic [4:0]  btn_x,
    input  logic [4:0]  btn_y,
    input  logic [15:0] switch,
    output logic        led_clk,
    output logic        led_do,
    output logic        led_pen,
    output logic        seg_clk,
    output logic        seg_do,
    output logic        seg_pen,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        vga_h_sync,
    output logic        vga_v_sync
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_S0    = H_VIS + H_FP;
    localparam int V_S0    = V_VIS + V_FP;
    // gfedcba segment patterns for 0..F, digit 0 in the low bits.
    localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic [4:0]  by1_q, by2_q, btn_s;
    logic [31:0] cnt_q, disp;
    logic [63:0] seg_data;
    logic [1:0]  pdiv_q;
    logic [9:0]  hc_q, vc_q;
    logic        hs_q, vs_q, pe, h_end, v_end, vis;
    logic [3:0]  red_q, green_q, blue_q;
    logic        unused;
    assign unused     = clk200P ^ clk200N;
    assign btn_x      = 5'b00000;
    assign btn_s      = ~by2_q;
    assign disp       = switch[1] ? {11'b0, btn_s, switch} : cnt_q;
    assign pe         = pdiv_q == 2'd3;
    assign h_end      = hc_q == 10'(H_TOTAL - 1);
    assign v_end      = vc_q == 10'(V_TOTAL - 1);
    assign vis        = hc_q < 10'(H_VIS) && vc_q < 10'(V_VIS);
    assign vga_red    = red_q;
    assign vga_green  = green_q;
    assign vga_blue   = blue_q;
    assign vga_h_sync = ~hs_q;
    assign vga_v_sync = ~vs_q;
    // Digit 7 sits in the top byte so it leaves the shifter first; segments are active-low, dp dark.
    always_comb begin
        seg_data = '0;
        for (int d = 0; d < 8; d++)
            seg_data[d*8 +: 8] = {1'b1, ~HEX[7*disp[d*4 +: 4] +: 7]};
    end
    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            by1_q   <= '0;
            by2_q   <= '0;
            cnt_q   <= '0;
            pdiv_q  <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            by1_q  <= btn_y;
            by2_q  <= by1_q;
            cnt_q  <= cnt_q + 32'(switch[0]);
            pdiv_q <= pdiv_q + 2'd1;
            if (pe) begin
                hc_q    <= h_end ? '0 : hc_q + 10'd1;
                vc_q    <= h_end ? (v_end ? '0 : vc_q + 10'd1) : vc_q;
                hs_q    <= hc_q >= 10'(H_S0) && hc_q < 10'(H_S0 + H_SYNC);
                vs_q    <= vc_q >= 10'(V_S0) && vc_q < 10'(V_S0 + V_SYNC);
                red_q   <= vis ? hc_q[7:4] : 4'h0;
                green_q <= vis ? vc_q[7:4] : 4'h0;
                blue_q  <= vis ? disp[3:0] : 4'h0;
            end
        end
    end
    pcpu_serial #(.W(16), .SER_DIV(SER_DIV)) u_led (
        .clk_i(clk_100mhz), .rst_ni(RSTN), .data_i(switch),
        .sclk_o(led_clk), .sdo_o(led_do), .pen_o(led_pen)
    );
    pcpu_serial #(.W(64), .SER_DIV(SER_DIV)) u_seg (
        .clk_i(clk_100mhz), .rst_ni(RSTN), .data_i(seg_data),
        .sclk_o(seg_clk), .sdo_o(seg_do), .pen_o(seg_pen)
    );
endmodule

// File: tb/tb_pcpu_board_top.sv
// tb_pcpu_board_top: directed stimulus with a frame-position model of the serial, counter and VGA outputs.
module tb_pcpu_board_top;
    localparam int SD = 4;
    // A short vertical frame keeps a full vsync cycle within a small run; horizontal timing is stock.
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic        clk_100mhz = 0, RSTN = 1, clk200P = 0, clk200N = 1;
    logic [4:0]  btn_y = 5'b11111;
    logic [15:0] switch = 16'h0000;
    logic [4:0]  btn_x;
    logic        led_clk, led_do, led_pen, seg_clk, seg_do, seg_pen, vga_h_sync, vga_v_sync;
    logic [3:0]  vga_red, vga_green, vga_blue;
    int          checks = 0, passes = 0;
    logic        chk_en = 0;

    pcpu_board_top #(.SER_DIV(SD), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
        .clk_100mhz(clk_100mhz), .RSTN(RSTN), .clk200P(clk200P), .clk200N(clk200N),
        .btn_x(btn_x), .btn_y(btn_y), .switch(switch),
        .led_clk(led_clk), .led_do(led_do), .led_pen(led_pen),
        .seg_clk(seg_clk), .seg_do(seg_do), .seg_pen(seg_pen),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int          e;
    logic [31:0] cnt_m;
    logic [4:0]  s1, s2;
    logic [15:0] led_snap;
    logic [63:0] seg_snap;
    logic [3:0]  b_m;
    wire  [31:0] m_disp = switch[1] ? {11'b0, ~s2, switch} : cnt_m;
    wire  [24:0] dut_v = {btn_x, led_clk, led_do, led_pen, seg_clk, seg_do, seg_pen,
                          vga_red, vga_green, vga_blue, vga_h_sync, vga_v_sync};

    function automatic logic [63:0] seg_enc(input logic [31:0] v);
        logic [63:0] r = '0;
        for (int d = 0; d < 8; d++) r[d*8 +: 8] = {1'b1, ~HEX[v[d*4 +: 4]]};
        return r;
    endfunction

    // {clk,do,pen} after ev clocks, from the tick's position inside a (2w+3)-tick frame.
    function automatic logic [2:0] ser_exp(input int ev, input int w, input logic [63:0] snap);
        int j, q, b;
        if (ev < SD) return 3'b000;
        j = ev / SD - 1;
        q = j % (2 * w + 3);
        b = q / 2;
        if (b > w - 1) b = w - 1;
        return {q <= 2 * w && q % 2 == 1, snap[w-1-b], q == 2 * w || q == 2 * w + 1};
    endfunction

    function automatic logic [13:0] vga_exp(input int ev, input logic [3:0] bb);
        int pm, hc, vc;
        logic vis;
        if (ev < 4) return 14'b11;
        pm  = ev / 4 - 1;
        hc  = pm % 800;
        vc  = (pm / 800) % VT;
        vis = hc < 640 && vc < VV;
        return {vis ? hc[7:4] : 4'h0, vis ? vc[7:4] : 4'h0, vis ? bb : 4'h0,
                !(hc >= 656 && hc < 752), !(vc >= VV + VF && vc < VV + VF + VS)};
    endfunction

    always @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            e <= 0; cnt_m <= 0; s1 <= 0; s2 <= 0; led_snap <= 0; seg_snap <= 0; b_m <= 0;
        end else begin
            e <= e + 1;
            if ((e + 1) % SD == 0 && ((e + 1) / SD - 1) % 35 == 0) led_snap <= switch;
            if ((e + 1) % SD == 0 && ((e + 1) / SD - 1) % 131 == 0) seg_snap <= seg_enc(m_disp);
            if ((e + 1) % 4 == 0) b_m <= m_disp[3:0];
            cnt_m <= cnt_m + 32'(switch[0]);
            s1 <= btn_y;
            s2 <= s1;
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    endtask

    task automatic tmo(input string nm);
        checks++;
        $display("FAIL %s: timed out, got no event, expected one at %0t", nm, $time);
    endtask

    always @(negedge clk_100mhz)
        if (chk_en)
            check("outputs", 64'(dut_v),
                  64'({5'b0, ser_exp(e, 16, 64'(led_snap)), ser_exp(e, 64, seg_snap), vga_exp(e, b_m)}));

    // Waits for a frame end (pen pulse) and collects the next frame's bits at shift-clock rises.
    task automatic capture(input bit seg, input int w, output logic [63:0] v);
        int t = 0, i = 0;
        logic pc = 0, c;
        v = '0;
        while (!(seg ? seg_pen : led_pen) && t < 3000) begin @(negedge clk_100mhz); t++; end
        while ((seg ? seg_pen : led_pen) && t < 3000) begin @(negedge clk_100mhz); t++; end
        while (i < w && t < 3000) begin
            @(negedge clk_100mhz);
            t++;
            c = seg ? seg_clk : led_clk;
            if (c && !pc) begin
                v = {v[62:0], seg ? seg_do : led_do};
                i++;
            end
            pc = c;
        end
        if (t >= 3000) tmo(seg ? "seg_capture" : "led_capture");
    endtask

    // Low width and fall-to-fall period of a sync line, in clocks.
    task automatic measure(input bit v, input int bound, output int low_len, output int period);
        int t = 0, idx = 0;
        logic p = 1;
        low_len = 0;
        period  = 0;
        while (t < bound) begin
            @(negedge clk_100mhz);
            t++;
            if (p && !(v ? vga_v_sync : vga_h_sync)) break;
            p = v ? vga_v_sync : vga_h_sync;
        end
        if (t >= bound) begin tmo(v ? "vsync_fall" : "hsync_fall"); return; end
        if (!v) check("blank_at_hsync", 64'({vga_red, vga_green, vga_blue}), 64'h0);
        while (idx < bound) begin
            @(negedge clk_100mhz);
            idx++;
            if ((v ? vga_v_sync : vga_h_sync) && low_len == 0) low_len = idx;
            if (!(v ? vga_v_sync : vga_h_sync) && low_len != 0) break;
        end
        if (idx >= bound) tmo(v ? "vsync_period" : "hsync_period");
        else period = idx;
    endtask

    initial begin
        logic [63:0] v;
        int n, lo, per;
        #1 RSTN = 0;
        chk_en = 1;
        repeat (10) @(negedge clk_100mhz);
        check("reset_outputs", 64'(dut_v), 64'h3);
        check("reset_cnt", 64'(cnt_m), 64'd0);
        RSTN = 1;
        switch = 16'h0001;
        repeat (100) @(negedge clk_100mhz);
        switch = 16'h0000;
        check("cnt_model_100", 64'(cnt_m), 64'd100);
        capture(1, 64, v);
        check("seg_cnt100", v, 64'hC0C0C0C0C0C08299);
        check("cnt_hold", 64'(cnt_m), 64'd100);
        switch = 16'hA5A5;
        capture(0, 16, v);
        check("led_a5a5", v, 64'hA5A5);
        n = 0;
        while (!led_pen && n < 100) begin @(negedge clk_100mhz); n++; end
        n = 0;
        while (led_pen && n < 100) begin @(negedge clk_100mhz); n++; end
        check("led_pen_len", 64'(n), 64'd8);
        switch = 16'h0002;
        btn_y  = 5'b11110;
        capture(1, 64, v);
        check("seg_btn_sw", v, 64'hC0C0C0F9C0C0C0A4);
        check("seg_first_byte", 64'(v[63:56]), 64'hC0);
        measure(0, 5000, lo, per);
        check("hsync_low", 64'(lo), 64'd384);
        check("hsync_period", 64'(per), 64'd3200);
        measure(1, 30000, lo, per);
        check("vsync_low", 64'(lo), 64'd6400);
        check("vsync_period", 64'(per), 64'(VT * 3200));
        n = 0;
        while (!seg_clk && n < 2000) begin @(negedge clk_100mhz); n++; end
        if (n >= 2000) tmo("seg_clk_high");
        #2 RSTN = 0;
        #1 check("seg_async_rst", 64'({seg_clk, seg_do, seg_pen}), 64'h0);
        check("vga_async_rst", 64'({vga_h_sync, vga_v_sync, vga_red, vga_green, vga_blue}), 64'h3000);
        repeat (3) @(negedge clk_100mhz);
        RSTN = 1;
        n = 0;
        while (!seg_clk && n < 100) begin @(negedge clk_100mhz); n++; end
        check("seg_restart", 64'(n), 64'd8);
        repeat (600) @(negedge clk_100mhz);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pcpu_board_top.md
Name: pcpu_board_top

Overview:
- Board-level I/O top for the SWORD FPGA board, clocked from clk_100mhz.
- Produces a 32-bit debug word from a run/hold cycle counter or from switches/buttons.
- Shifts the debug word serially to the 8-digit 7-segment display and the switches to the 16 LEDs.
- Generates 640x480@60 VGA timing with a fixed test pattern.
- Pipelined CPU core is out of scope; it attaches later by replacing the debug-word source.

Parameters:
- SER_DIV, 4: clk_100mhz cycles per half period of led_clk/seg_clk (minimum 1).
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal pixel counts.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical line counts.

Ports:
- clk_100mhz  in  1  sole clock, 100 MHz, all logic rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- clk200P, clk200N  in  1 each  differential 200 MHz pins; unused, kept for pinout.
- btn_x  out  5  button matrix column drive.
- btn_y  in  5  button matrix rows; low = pressed.
- switch  in  16  slide switches.
- led_clk, led_do, led_pen  out  1 each  LED shift clock, data, latch.
- seg_clk, seg_do, seg_pen  out  1 each  7-seg shift clock, data, latch.
- vga_red, vga_green, vga_blue  out  4 each  VGA colour.
- vga_h_sync, vga_v_sync  out  1 each  VGA syncs, active low.

Behaviour:
- Reset (RSTN=0, async): all registers 0, vga_h_sync=vga_v_sync=1, colours 0, btn_x=0, led_*/seg_* = 0.
- btn_x is constantly 5'b00000.
- btn_y passes through a 2-FF synchronizer; btn_s = ~sync (1 = pressed).
- cnt (32b): increments by 1 per clock while switch[0]=1; holds while switch[0]=0; wraps FFFFFFFF->0.
- disp = switch[1] ? {11'b0, btn_s, switch} : cnt.
- Serial engines, two independent copies of one FSM (LED: 16 bits = switch; SEG: 64 bits):
  - Tick every SER_DIV clocks.
  - LOAD: snapshot data, pen=0.
  - SHIFT: MSB first; do changes while clk=0; clk rises mid-bit; after the last bit clk=0.
  - LATCH: pen=1 for exactly 2 ticks, then LOAD again. Runs forever.
  - The snapshot is stable for the whole frame.
- SEG frame order: digit 7 (disp[31:28]) first, digit 0 last.
- Each digit is 8 bits {dp,g,f,e,d,c,b,a}, active-low (0 = lit), dp always 1.
- Hex map (gfedcba, active-high before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- VGA pixel timing:
  - Pixel enable every 4th clock (25 MHz).
  - hc runs 0..H_TOTAL-1 (800); vc increments when hc wraps and runs 0..V_TOTAL-1 (525).
  - vga_h_sync=0 for hc in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC) = [656,752).
  - vga_v_sync=0 for vc in [490,492).
- VGA colour:
  - Visible (hc<640, vc<480): red=hc[7:4], green=vc[7:4], blue=disp[3:0].
  - Blank elsewhere: colours 0.
  - Outputs are registered, one pixel of latency.

Test Plan:
- Hold RSTN=0 after 100 ns with clk_100mhz toggling every 5 ns -> every output stays at its reset value, cnt stays 0.
- Release reset, switch=16'h0001 for 100 clocks -> cnt=100. Set switch[0]=0 -> cnt holds at 100. switch=16'h0000 -> cnt remains 100.
- switch=16'hA5A5 -> LED frame on led_do (sampled at led_clk rising) = 1010010110100101. led_pen high for 2 ticks after bit 16.
- switch=16'h0002 with btn_y[0] held low -> disp=0x00010002. seg_do first byte = 0xC0 (digit 7 = '0' active-low with dp); last byte = 0xA4 ('2').
- Free-run VGA -> h period 3200 clocks; hsync low 384 clocks starting at hc=656; vsync low for 2 lines per 525-line frame; colours 0 when hc>=640.
- Assert RSTN low mid-SEG-frame -> seg_clk/seg_do/seg_pen drop to 0 immediately. After release, a fresh frame starts from LOAD.
